// File: rtl/inst_mem_loader.sv
// Program-image loader: takes a framed byte stream (count, payload, checksum)
// and writes each payload byte into instruction memory while the CPU is held.
//
// Ports:
//   clk, rst            clock and asynchronous active-low reset
//   start               begin a load (honoured in IDLE, DONE or ERR)
//   in_data, in_valid   stream byte and its valid qualifier
//   in_ready            loader accepts a byte this cycle
//   mem_we, mem_addr,   registered byte write toward instruction memory
//   mem_wdata
//   cpu_hold            held high while a load is in progress
//   done                one-cycle pulse after a good checksum
//   error               sticky; set on oversize count or bad checksum
module inst_mem_loader #(
    parameter int ADDR_SIZE     = 32,
    parameter int MEM_SIZE      = 1024,
    parameter int MEM_CELL_SIZE = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [MEM_CELL_SIZE-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [ADDR_SIZE-1:0]     mem_addr,
    output logic [MEM_CELL_SIZE-1:0] mem_wdata,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     error
);

    localparam int          IW        = $clog2(MEM_SIZE) + 1;
    localparam logic [15:0] MAX_WORDS = 16'(MEM_SIZE / 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t                   state_q, state_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [MEM_CELL_SIZE-1:0] csum_q, csum_d;
    logic                     we_q, we_d;
    logic [IW-1:0]            addr_q, addr_d;
    logic [MEM_CELL_SIZE-1:0] wdata_q, wdata_d;
    logic                     hold_q, hold_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic        xfer;
    logic [15:0] hdr_cnt;
    logic        last_byte;

    assign in_ready = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
    assign xfer     = in_valid & in_ready;

    // Full 16-bit count as it will look once the high byte is latched.
    assign hdr_cnt  = {8'(in_data), cnt_q[7:0]};

    // Current byte is the last payload byte when idx+1 == 4*N.
    assign last_byte = (32'(idx_q) + 32'd1) == {14'd0, cnt_q, 2'b00};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HDR_LO;
                    err_d   = 1'b0;
                    csum_d  = '0;
                    idx_d   = '0;
                    hold_d  = 1'b1;
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    cnt_d[7:0] = 8'(in_data);
                    state_d    = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (xfer) begin
                    cnt_d = hdr_cnt;
                    if (hdr_cnt > MAX_WORDS) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        hold_d  = 1'b0;
                    end else if (hdr_cnt == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q;
                    wdata_d = in_data;
                    csum_d  = csum_q ^ in_data;
                    idx_d   = idx_q + IW'(1);
                    if (last_byte) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    hold_d = 1'b0;
                    if (in_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = ADDR_SIZE'(addr_q);
    assign mem_wdata = wdata_q;
    assign cpu_hold  = hold_q;
    assign done      = done_q;
    assign error     = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: drives framed byte streams and checks
// every memory write against a queue of expected (addr, data, cycle) entries.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t q[$];
    int  vec  = 0;
    int  miss = 0;
    int  cyc  = 0;
    int  paddr = 0;

    inst_mem_loader #(
        .ADDR_SIZE    (32),
        .MEM_SIZE     (1024),
        .MEM_CELL_SIZE(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every mem_we must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && mem_we) begin
            if (q.size() == 0) begin
                chk("spurious_we", {mem_addr[23:0], mem_wdata}, 32'hFFFFFFFF);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_addr", mem_addr, 32'(e.addr));
                chk("wr_data", 32'(mem_wdata), 32'(e.data));
                chk("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        paddr = 0;
        chk("start_hold", 32'(cpu_hold), 32'd1);
        chk("start_err", 32'(error), 32'd0);
        chk("start_rdy", 32'(in_ready), 32'd1);
    endtask

    // Present one byte; returns at the negedge before its accepting edge.
    task automatic send(input logic [7:0] b, input bit payload);
        int n;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("rdy_timeout", 32'(in_ready), 32'd1);
        end else if (payload) begin
            q.push_back('{addr: paddr, data: int'(b), cyc: cyc + 1});
            paddr++;
        end
    endtask

    task automatic gap();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_state", {25'd0, in_ready, mem_we, cpu_hold, done, error,
                          2'b00}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_rdy", 32'(in_ready), 32'd0);

        // Single word, back-to-back.
        do_start();
        send(8'h01, 0); send(8'h00, 0);
        send(8'h0A, 1); send(8'h00, 1); send(8'h20, 1); send(8'h80, 1);
        send(8'hAA, 0);
        chk("s1_hold_pre", 32'(cpu_hold), 32'd1);
        end_frame();
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_hold", 32'(cpu_hold), 32'd0);
        chk("s1_err", 32'(error), 32'd0);
        chk("s1_rdy", 32'(in_ready), 32'd0);
        chk("s1_q", 32'(q.size()), 32'd0);
        @(negedge clk);
        chk("s1_done_pulse", 32'(done), 32'd0);

        // Same frame with 3-cycle valid gaps.
        do_start();
        send(8'h01, 0); gap(); send(8'h00, 0); gap();
        send(8'h0A, 1); gap(); send(8'h00, 1); gap();
        send(8'h20, 1); gap(); send(8'h80, 1); gap();
        send(8'hAA, 0);
        end_frame();
        chk("s2_done", 32'(done), 32'd1);
        chk("s2_err", 32'(error), 32'd0);
        chk("s2_q", 32'(q.size()), 32'd0);

        // Zero count.
        do_start();
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        end_frame();
        chk("s3_done", 32'(done), 32'd1);
        chk("s3_err", 32'(error), 32'd0);
        chk("s3_hold", 32'(cpu_hold), 32'd0);

        // Oversize count N=257.
        do_start();
        send(8'h01, 0); send(8'h01, 0);
        end_frame();
        chk("s4_err", 32'(error), 32'd1);
        chk("s4_hold", 32'(cpu_hold), 32'd0);
        chk("s4_rdy", 32'(in_ready), 32'd0);
        chk("s4_done", 32'(done), 32'd0);
        do_start();
        chk("s4_clr", 32'(error), 32'd0);

        // Bad checksum (loader already in HDR_LO).
        send(8'h01, 0); send(8'h00, 0);
        send(8'h0A, 1); send(8'h00, 1); send(8'h20, 1); send(8'h80, 1);
        send(8'h55, 0);
        end_frame();
        chk("s5_err", 32'(error), 32'd1);
        chk("s5_done", 32'(done), 32'd0);
        chk("s5_hold", 32'(cpu_hold), 32'd0);
        chk("s5_q", 32'(q.size()), 32'd0);
        @(negedge clk);
        chk("s5_sticky", 32'(error), 32'd1);

        // Reset after two payload bytes.
        do_start();
        send(8'h02, 0); send(8'h00, 0);
        send(8'h11, 1); send(8'h22, 1);
        @(posedge clk);
        #2;
        chk("s6_we_pre", 32'(mem_we), 32'd1);
        rst = 1'b0;
        #1;
        chk("s6_outs", {25'd0, in_ready, mem_we, cpu_hold, done, error,
                        2'b00}, 32'd0);
        chk("s6_addr", mem_addr, 32'd0);
        chk("s6_wdata", 32'(mem_wdata), 32'd0);
        q.delete();
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("s6_rdy", 32'(in_ready), 32'd0);
        chk("s6_hold", 32'(cpu_hold), 32'd0);

        // Clean reload after the abort.
        do_start();
        send(8'h01, 0); send(8'h00, 0);
        send(8'h0A, 1); send(8'h00, 1); send(8'h20, 1); send(8'h80, 1);
        send(8'hAA, 0);
        end_frame();
        chk("s7_done", 32'(done), 32'd1);
        chk("s7_q", 32'(q.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
